// File: rtl/arbitro_rr_tx_if.sv
// arbitro_rr_tx_if: bundle between the four input lanes, the round-robin
// scheduler and the phy_tx parallel-serial stage.
//   in0..in3        lane bytes, consumed when the matching pop is high
//   validin0..3     lane k has a byte available
//   stall           downstream not accepting
//   pop0..pop3      lane k byte consumed this cycle (combinational)
//   grant           one-hot current grant, 0 when idle
//   data_out        registered byte towards phy_tx
//   valid_out       data_out carries a lane byte
//   lane_out        source lane of data_out
// master: lane/downstream side (drives inputs); slave: the scheduler.
interface arbitro_rr_tx_if;
    logic [7:0] in0, in1, in2, in3;
    logic       validin0, validin1, validin2, validin3;
    logic       stall;
    logic       pop0, pop1, pop2, pop3;
    logic [3:0] grant;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_out;

    modport master (
        output in0, in1, in2, in3,
        output validin0, validin1, validin2, validin3,
        output stall,
        input  pop0, pop1, pop2, pop3,
        input  grant, data_out, valid_out, lane_out
    );

    modport slave (
        input  in0, in1, in2, in3,
        input  validin0, validin1, validin2, validin3,
        input  stall,
        output pop0, pop1, pop2, pop3,
        output grant, data_out, valid_out, lane_out
    );
endinterface

// File: rtl/arbitro_rr_tx.sv
// arbitro_rr_tx: round-robin scheduler sharing the phy_tx byte path between
// four lanes. One lane is granted at a time for bursts of up to MAX_BURST
// bytes; popped bytes appear one cycle later on a registered stream with
// their source lane. IDLE_BYTE is driven whenever no byte is delivered.
//   clk_4f  single clock, all state on posedge
//   reset   synchronous, active-high
//   bus     arbitro_rr_tx_if.slave (lane inputs, pops, grant, output stream)
module arbitro_rr_tx #(
    parameter int         MAX_BURST = 4,
    parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
    input  logic clk_4f,
    input  logic reset,
    arbitro_rr_tx_if.slave bus
);
    typedef enum logic {IDLE, SERVE} state_t;

    state_t          state, state_nx;
    logic [1:0]      ptr, ptr_nx;
    logic [7:0]      burst_cnt, burst_cnt_nx;
    logic [3:0]      grant, grant_nx;
    logic [7:0]      data_out;
    logic            valid_out;
    logic [1:0]      lane_out;

    logic [3:0]      req;
    logic [3:0][7:0] lane_data;
    logic [1:0]      g;
    logic            pop_g;
    logic            rel;

    assign req       = {bus.validin3, bus.validin2, bus.validin1, bus.validin0};
    assign lane_data = {bus.in3, bus.in2, bus.in1, bus.in0};

    // One-hot of the first requester at s, s+1, s+2, s+3 (mod 4); 0 if none.
    // Scanning from the far end lets the closest requester overwrite last.
    function automatic logic [3:0] pick(input logic [3:0] r, input logic [1:0] s);
        logic [3:0] oh;
        logic [1:0] idx;
        oh = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = s + 2'(i);
            if (r[idx]) oh = 4'b0001 << idx;
        end
        return oh;
    endfunction

    always_comb begin
        g = '0;
        for (int k = 0; k < 4; k++)
            if (grant[k]) g = 2'(k);
    end

    // Pop is suppressed while reset is high so no lane loses a byte that the
    // reset would drop anyway.
    assign pop_g = (state == SERVE) & req[g] & ~bus.stall & ~reset;
    // Release on a full burst or when the granted lane runs dry; a stall alone
    // never releases, but a lane dropping valid during a stall does.
    assign rel   = (pop_g && burst_cnt == 8'(MAX_BURST - 1)) || !req[g];

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        burst_cnt_nx = burst_cnt;
        grant_nx     = grant;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nx     = SERVE;
                    grant_nx     = pick(req, ptr);
                    burst_cnt_nx = '0;
                end
            end
            SERVE: begin
                if (rel) begin
                    // The released lane is searched last, so a sole requester
                    // is re-granted with no bubble.
                    ptr_nx       = g + 2'd1;
                    grant_nx     = pick(req, g + 2'd1);
                    burst_cnt_nx = '0;
                    state_nx     = (|pick(req, g + 2'd1)) ? SERVE : IDLE;
                end else if (pop_g) begin
                    burst_cnt_nx = burst_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            burst_cnt <= '0;
            grant     <= '0;
            data_out  <= IDLE_BYTE;
            valid_out <= 1'b0;
            lane_out  <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            burst_cnt <= burst_cnt_nx;
            grant     <= grant_nx;
            if (pop_g) begin
                data_out  <= lane_data[g];
                valid_out <= 1'b1;
                lane_out  <= g;
            end else begin
                // lane_out holds its last source on idle cycles
                data_out  <= IDLE_BYTE;
                valid_out <= 1'b0;
            end
        end
    end

    assign bus.pop0      = pop_g & (g == 2'd0);
    assign bus.pop1      = pop_g & (g == 2'd1);
    assign bus.pop2      = pop_g & (g == 2'd2);
    assign bus.pop3      = pop_g & (g == 2'd3);
    assign bus.grant     = grant;
    assign bus.data_out  = data_out;
    assign bus.valid_out = valid_out;
    assign bus.lane_out  = lane_out;
endmodule

// File: tb/tb_arbitro_rr_tx.sv
// tb_arbitro_rr_tx: directed scenarios plus a randomized run against a
// lane/ownership reference model of the round-robin scheduler.
module tb_arbitro_rr_tx;
    localparam int MB = 4;
    localparam logic [7:0] IDLE = 8'hBC;

    logic clk_4f = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_4f = ~clk_4f;

    arbitro_rr_tx_if bus();

    arbitro_rr_tx #(.MAX_BURST(MB), .IDLE_BYTE(IDLE)) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] v  = '0;
    logic       st = 1'b0;
    logic [7:0] base    [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] pop_cnt [4] = '{8'd0, 8'd0, 8'd0, 8'd0};

    // Each lane presents base + (bytes consumed so far) as its head byte.
    assign bus.in0 = base[0] + pop_cnt[0];
    assign bus.in1 = base[1] + pop_cnt[1];
    assign bus.in2 = base[2] + pop_cnt[2];
    assign bus.in3 = base[3] + pop_cnt[3];
    assign bus.validin0 = v[0];
    assign bus.validin1 = v[1];
    assign bus.validin2 = v[2];
    assign bus.validin3 = v[3];
    assign bus.stall    = st;

    always @(posedge clk_4f) begin
        if (bus.pop0) pop_cnt[0] <= pop_cnt[0] + 8'd1;
        if (bus.pop1) pop_cnt[1] <= pop_cnt[1] + 8'd1;
        if (bus.pop2) pop_cnt[2] <= pop_cnt[2] + 8'd1;
        if (bus.pop3) pop_cnt[3] <= pop_cnt[3] + 8'd1;
    end

    function automatic logic [3:0] popv();
        return {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
    endfunction

    function automatic int first_req(input logic [3:0] r, input int s);
        for (int j = 0; j < 4; j++)
            if (r[(s + j) % 4]) return (s + j) % 4;
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic set_base(input int k, input logic [7:0] first);
        base[k] = first - pop_cnt[k];
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1; v = '0; st = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; v = '0; st = 1'b0;
        @(posedge clk_4f);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            v = 4'hF;
            @(negedge clk_4f);
            n_cmp++;
            if ({popv(), bus.grant, bus.valid_out, bus.data_out, bus.lane_out} !==
                {4'b0, 4'b0, 1'b0, IDLE, 2'd0}) begin
                n_err++;
                $display("FAIL reset c%0d: pop=%b grant=%b valid=%b data=%h lane=%0d expected 0/0/0/bc/0",
                         c, popv(), bus.grant, bus.valid_out, bus.data_out, bus.lane_out);
            end
        end
    endtask

    task automatic test_single_lane();
        do_reset();
        set_base(2, 8'h10);
        next_cycle();
        v = 4'b0100;
        @(negedge clk_4f);
        n_cmp++;
        if (bus.grant !== 4'b0000) begin
            n_err++; $display("FAIL single_arb_latency: grant=%b expected 0000", bus.grant);
        end
        next_cycle();
        @(negedge clk_4f);
        n_cmp++;
        if ({bus.grant, popv()} !== {4'b0100, 4'b0100}) begin
            n_err++; $display("FAIL single_grant: grant=%b pop=%b expected 0100/0100", bus.grant, popv());
        end
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            @(negedge clk_4f);
            n_cmp++;
            if ({bus.valid_out, bus.lane_out, bus.data_out, bus.grant} !==
                {1'b1, 2'd2, 8'(8'h10 + i), 4'b0100}) begin
                n_err++;
                $display("FAIL single_stream i%0d: valid=%b lane=%0d data=%h grant=%b expected 1/2/%h/0100",
                         i, bus.valid_out, bus.lane_out, bus.data_out, bus.grant, 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_all_lanes();
        int ln;
        logic [7:0] ed;
        do_reset();
        for (int k = 0; k < 4; k++) set_base(k, 8'(8'h40 * k));
        next_cycle();
        v = 4'hF;
        next_cycle();
        for (int i = 0; i < 24; i++) begin
            next_cycle();
            @(negedge clk_4f);
            ln = (i / 4) % 4;
            ed = 8'(8'h40 * ln + (i / 16) * 4 + i % 4);
            n_cmp++;
            if ({bus.valid_out, bus.lane_out, bus.data_out} !== {1'b1, 2'(ln), ed}) begin
                n_err++;
                $display("FAIL all_lanes i%0d: valid=%b lane=%0d data=%h expected 1/%0d/%h",
                         i, bus.valid_out, bus.lane_out, bus.data_out, ln, ed);
            end
        end
    endtask

    task automatic test_stall();
        logic [10:0] exp_t [9];
        exp_t[2] = {1'b1, 2'd1, 8'h20};
        exp_t[3] = {1'b1, 2'd1, 8'h21};
        exp_t[4] = {1'b0, 2'd1, IDLE};
        exp_t[5] = {1'b0, 2'd1, IDLE};
        exp_t[6] = {1'b1, 2'd1, 8'h22};
        exp_t[7] = {1'b1, 2'd1, 8'h23};
        exp_t[8] = {1'b1, 2'd2, 8'h30};
        do_reset();
        set_base(1, 8'h20);
        set_base(2, 8'h30);
        for (int t = 0; t < 9; t++) begin
            next_cycle();
            if (t == 0) v = 4'b0110;
            st = (t == 3 || t == 4);
            @(negedge clk_4f);
            if (t == 3) begin
                n_cmp++;
                if ({popv(), bus.grant} !== {4'b0000, 4'b0010}) begin
                    n_err++; $display("FAIL stall_freeze: pop=%b grant=%b expected 0000/0010", popv(), bus.grant);
                end
            end
            if (t == 7) begin
                n_cmp++;
                if (bus.grant !== 4'b0100) begin
                    n_err++; $display("FAIL stall_rotate: grant=%b expected 0100", bus.grant);
                end
            end
            if (t >= 2) begin
                n_cmp++;
                if ({bus.valid_out, bus.lane_out, bus.data_out} !== exp_t[t]) begin
                    n_err++;
                    $display("FAIL stall_stream t%0d: got %h expected %h", t,
                             {bus.valid_out, bus.lane_out, bus.data_out}, exp_t[t]);
                end
            end
        end
        st = 1'b0;
    endtask

    task automatic test_drop();
        do_reset();
        set_base(0, 8'h50);
        set_base(3, 8'h70);
        for (int t = 0; t < 6; t++) begin
            next_cycle();
            if (t == 0) v = 4'b1001;
            if (t == 3) v = 4'b1000;
            @(negedge clk_4f);
            if (t == 3) begin
                n_cmp++;
                if ({popv(), bus.grant, bus.valid_out, bus.data_out} !== {4'b0000, 4'b0001, 1'b1, 8'h51}) begin
                    n_err++; $display("FAIL drop_before: pop=%b grant=%b valid=%b data=%h expected 0000/0001/1/51",
                                      popv(), bus.grant, bus.valid_out, bus.data_out);
                end
            end
            if (t == 4) begin
                n_cmp++;
                if ({popv(), bus.grant} !== {4'b1000, 4'b1000}) begin
                    n_err++; $display("FAIL drop_regrant: pop=%b grant=%b expected 1000/1000", popv(), bus.grant);
                end
            end
            if (t == 5) begin
                n_cmp++;
                if ({bus.valid_out, bus.lane_out, bus.data_out} !== {1'b1, 2'd3, 8'h70}) begin
                    n_err++; $display("FAIL drop_data: valid=%b lane=%0d data=%h expected 1/3/70",
                                      bus.valid_out, bus.lane_out, bus.data_out);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_base(2, 8'h90);
        for (int t = 0; t < 5; t++) begin
            next_cycle();
            if (t == 0) v = 4'b0100;
            if (t == 2) reset = 1'b1;
            if (t == 3) begin reset = 1'b0; v = 4'hF; end
            @(negedge clk_4f);
            if (t == 1) begin
                n_cmp++;
                if (bus.grant !== 4'b0100) begin
                    n_err++; $display("FAIL rmid_grant: grant=%b expected 0100", bus.grant);
                end
            end
            if (t == 3) begin
                n_cmp++;
                if ({bus.grant, bus.valid_out, bus.lane_out, bus.data_out} !== {4'b0, 1'b0, 2'd0, IDLE}) begin
                    n_err++; $display("FAIL rmid_reset: grant=%b valid=%b lane=%0d data=%h expected 0/0/0/bc",
                                      bus.grant, bus.valid_out, bus.lane_out, bus.data_out);
                end
            end
            if (t == 4) begin
                n_cmp++;
                if ({bus.grant, popv()} !== {4'b0001, 4'b0001}) begin
                    n_err++; $display("FAIL rmid_restart: grant=%b pop=%b expected 0001/0001", bus.grant, popv());
                end
            end
        end
    endtask

    // Model: owner lane (-1 = none), bytes taken in current grant, search start,
    // and the byte the output register will show.
    task automatic test_random();
        int owner, taken, ptr;
        logic [7:0] md;
        logic       mv;
        logic [1:0] ml;
        logic [3:0] ep, eg;
        logic [7:0] lin [4];
        do_reset();
        for (int k = 0; k < 4; k++) base[k] = 8'($urandom_range(255));
        owner = -1; taken = 0; ptr = 0; md = IDLE; mv = 1'b0; ml = 2'd0;
        for (int c = 0; c < 800; c++) begin
            next_cycle();
            reset = ($urandom_range(99) < 2);
            for (int k = 0; k < 4; k++) v[k] = ($urandom_range(9) < 6);
            st = ($urandom_range(3) == 0);
            ep = '0;
            if (!reset && owner >= 0 && v[owner] && !st) ep[owner] = 1'b1;
            eg = (owner < 0) ? 4'b0 : 4'(1 << owner);
            @(negedge clk_4f);
            n_cmp++;
            if ({popv(), bus.grant} !== {ep, eg}) begin
                n_err++; $display("FAIL rand_ctrl c%0d: pop=%b grant=%b expected %b/%b", c, popv(), bus.grant, ep, eg);
            end
            n_cmp++;
            if ({bus.valid_out, bus.lane_out, bus.data_out} !== {mv, ml, md}) begin
                n_err++; $display("FAIL rand_out c%0d: valid=%b lane=%0d data=%h expected %b/%0d/%h",
                                  c, bus.valid_out, bus.lane_out, bus.data_out, mv, ml, md);
            end
            lin[0] = bus.in0; lin[1] = bus.in1; lin[2] = bus.in2; lin[3] = bus.in3;
            if (reset) begin
                owner = -1; taken = 0; ptr = 0; md = IDLE; mv = 1'b0; ml = 2'd0;
            end else begin
                if (ep != 0) begin md = lin[owner]; mv = 1'b1; ml = 2'(owner); end
                else begin md = IDLE; mv = 1'b0; end
                if (owner < 0) begin
                    if (v != 0) begin owner = first_req(v, ptr); taken = 0; end
                end else begin
                    if (ep != 0) taken++;
                    if (taken == MB || !v[owner]) begin
                        ptr = (owner + 1) % 4;
                        owner = first_req(v, ptr);
                        taken = 0;
                    end
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_lane();
        test_all_lanes();
        test_stall();
        test_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
